// File: rtl/sha_mem_loader_if.sv
// Byte-stream handshakes for sha_mem_loader: rx carries framed records in,
// tx carries the 32 digest bytes out; slave is the loader side.
interface sha_mem_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  tx_ready,
    output rx_ready,
    output tx_data,
    output tx_valid
  );

  modport master (
    output rx_data,
    output rx_valid,
    output tx_ready,
    input  rx_ready,
    input  tx_data,
    input  tx_valid
  );
endinterface

// File: rtl/sha_mem_loader.sv
// Parses hdr/addr/data records into DMAD/DMAI writes, runs the core on GO,
// and streams the 256-bit digest back MSB byte first over bus.tx_*.
module sha_mem_loader #(
  parameter int unsigned WE_PULSE = 1
) (
  input  logic         clk,
  input  logic         reset,
  sha_mem_loader_if.slave bus,
  output logic [31:0]  DMAD_addr_o,
  output logic [31:0]  DMAD_data_o,
  output logic [7:0]   DMAD_wea_o,
  output logic [31:0]  DMAI_addr_o,
  output logic [31:0]  DMAI_data_o,
  output logic [7:0]   DMAI_wea_o,
  output logic         start_o,
  input  logic         state_done_i,
  input  logic [255:0] res_sha256_i,
  output logic [15:0]  load_count,
  output logic         hdr_err
);

  typedef enum logic [2:0] {
    S_HDR,
    S_ADDR,
    S_DATA,
    S_WRITE,
    S_GAP,
    S_RUN,
    S_DUMP
  } state_e;

  localparam logic [4:0] PULSE_LAST = 5'(WE_PULSE - 1);

  state_e       state_q;
  state_e       state_d;
  logic [4:0]   cnt_q;
  logic         cnt_inc;
  logic         port_i_q;
  logic [31:0]  addr_sr_q;
  logic [23:0]  data_sr_q;
  logic [255:0] dig_q;
  logic         done_q;
  logic         alive_q;

  logic rx_fire;
  logic tx_fire;
  logic hdr_mem;
  logic hdr_go;
  logic last4;
  logic pulse_end;
  logic dump_end;
  logic done_rise;

  assign rx_fire   = bus.rx_valid & bus.rx_ready;
  assign tx_fire   = bus.tx_valid & bus.tx_ready;
  assign hdr_mem   = (bus.rx_data == 8'h01) ||
                     (bus.rx_data == 8'h02);
  assign hdr_go    = bus.rx_data == 8'h03;
  assign last4     = cnt_q == 5'd3;
  assign pulse_end = cnt_q == PULSE_LAST;
  assign dump_end  = cnt_q == 5'd31;
  // done already high when RUN is entered has done_q = 1: no edge
  assign done_rise = state_done_i & ~done_q;

  always_comb begin
    state_d = state_q;
    cnt_inc = 1'b0;
    unique case (state_q)
      S_HDR: begin
        if (rx_fire) begin
          unique case (1'b1)
            hdr_mem: state_d = S_ADDR;
            hdr_go:  state_d = S_RUN;
            default: state_d = S_HDR;
          endcase
        end
      end
      S_ADDR: begin
        cnt_inc = rx_fire;
        if (rx_fire && last4) state_d = S_DATA;
      end
      S_DATA: begin
        cnt_inc = rx_fire;
        if (rx_fire && last4) state_d = S_WRITE;
      end
      S_WRITE: begin
        cnt_inc = 1'b1;
        if (pulse_end) state_d = S_GAP;
      end
      S_GAP: state_d = S_HDR;
      S_RUN: begin
        if (done_rise) state_d = S_DUMP;
      end
      S_DUMP: begin
        cnt_inc = tx_fire;
        if (tx_fire && dump_end) state_d = S_HDR;
      end
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_HDR;
    else        state_q <= state_d;
  end

  // alive_q holds rx_ready low until the first edge after reset
  assign bus.rx_ready = alive_q &
    ((state_q == S_HDR) ||
     (state_q == S_ADDR) ||
     (state_q == S_DATA));
  assign bus.tx_valid = state_q == S_DUMP;
  assign bus.tx_data  = dig_q[255:248];
  assign start_o      = (state_q == S_RUN) ||
                        (state_q == S_DUMP);
  assign DMAD_wea_o   = (state_q == S_WRITE && !port_i_q) ?
                        8'hFF : 8'h00;
  assign DMAI_wea_o   = (state_q == S_WRITE && port_i_q) ?
                        8'hFF : 8'h00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alive_q     <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      port_i_q    <= 1'b0;
      addr_sr_q   <= '0;
      data_sr_q   <= '0;
      dig_q       <= '0;
      DMAD_addr_o <= '0;
      DMAD_data_o <= '0;
      DMAI_addr_o <= '0;
      DMAI_data_o <= '0;
      load_count  <= '0;
      hdr_err     <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      done_q  <= state_done_i;
      cnt_q   <= (state_d != state_q) ?
                 5'd0 : cnt_q + 5'(cnt_inc);

      if (state_q == S_HDR && rx_fire) begin
        // 01 -> DMAD, 02 -> DMAI: bit 1 selects the port
        if (hdr_mem)     port_i_q <= bus.rx_data[1];
        else if (!hdr_go) hdr_err <= 1'b1;
      end

      if (state_q == S_ADDR && rx_fire)
        addr_sr_q <= {addr_sr_q[23:0], bus.rx_data};

      if (state_q == S_DATA && rx_fire) begin
        data_sr_q <= {data_sr_q[15:0], bus.rx_data};
        // last data byte merges straight into the port register
        if (last4) begin
          if (port_i_q) begin
            DMAI_addr_o <= addr_sr_q;
            DMAI_data_o <= {data_sr_q, bus.rx_data};
          end else begin
            DMAD_addr_o <= addr_sr_q;
            DMAD_data_o <= {data_sr_q, bus.rx_data};
          end
        end
      end

      if (state_q == S_WRITE && pulse_end &&
          load_count != 16'hFFFF)
        load_count <= load_count + 16'd1;

      if (state_q == S_RUN && done_rise)
        dig_q <= res_sha256_i;
      else if (tx_fire)
        dig_q <= {dig_q[247:0], 8'h00};
    end
  end

endmodule

// File: tb/tb_sha_mem_loader.sv
// Directed + randomized bench for sha_mem_loader with a record-level
// reference model (last write per port, record count, error flag).
module tb_sha_mem_loader;
  localparam int WE = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sha_mem_loader_if bus();

  logic [31:0]  dmad_addr;
  logic [31:0]  dmad_data;
  logic [7:0]   dmad_wea;
  logic [31:0]  dmai_addr;
  logic [31:0]  dmai_data;
  logic [7:0]   dmai_wea;
  logic         start;
  logic         done;
  logic [255:0] res;
  logic [15:0]  lcnt;
  logic         herr;

  sha_mem_loader #(.WE_PULSE(WE)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .DMAD_addr_o  (dmad_addr),
    .DMAD_data_o  (dmad_data),
    .DMAD_wea_o   (dmad_wea),
    .DMAI_addr_o  (dmai_addr),
    .DMAI_data_o  (dmai_data),
    .DMAI_wea_o   (dmai_wea),
    .start_o      (start),
    .state_done_i (done),
    .res_sha256_i (res),
    .load_count   (lcnt),
    .hdr_err      (herr)
  );

  int tests = 0;
  int fails = 0;
  int pd = 0;
  int pi = 0;

  logic [31:0] m_dad, m_dd, m_iad, m_id;
  int          m_cnt;
  logic        m_err;

  always @(negedge clk) begin
    if (dmad_wea == 8'hFF) pd++;
    if (dmai_wea == 8'hFF) pi++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_dad = '0; m_dd = '0; m_iad = '0; m_id = '0;
    m_cnt = 0;  m_err = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dmad"}, {dmad_addr, dmad_data, dmad_wea}, '0);
    chk({tag, "_dmai"}, {dmai_addr, dmai_data, dmai_wea}, '0);
    chk({tag, "_tx"}, {bus.tx_valid, bus.tx_data}, '0);
    chk({tag, "_misc"}, {start, lcnt, herr, bus.rx_ready}, '0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("rx_timeout", 0, 1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_record(input logic [7:0] hdr,
                             input logic [31:0] addr,
                             input logic [31:0] data,
                             input int gap);
    int spd, spi;
    spd = pd;
    spi = pi;
    send_byte(hdr, gap);
    for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8], gap);
    for (int i = 3; i >= 0; i--) send_byte(data[8*i +: 8], gap);
    if (hdr == 8'h01) begin
      m_dad = addr; m_dd = data;
    end else begin
      m_iad = addr; m_id = data;
    end
    if (m_cnt < 65535) m_cnt++;
    chk("wea_sel", (hdr == 8'h01) ? dmad_wea : dmai_wea, 8'hFF);
    chk("wea_other", (hdr == 8'h01) ? dmai_wea : dmad_wea, 8'h00);
    chk("dmad_addr", dmad_addr, m_dad);
    chk("dmad_data", dmad_data, m_dd);
    chk("dmai_addr", dmai_addr, m_iad);
    chk("dmai_data", dmai_data, m_id);
    chk("rx_ready_write", bus.rx_ready, 0);
    repeat (WE) @(negedge clk);
    chk("gap_wea", {dmad_wea, dmai_wea}, 0);
    chk("gap_count", lcnt, m_cnt);
    chk("gap_rx_ready", bus.rx_ready, 0);
    @(negedge clk);
    chk("hdr_rx_ready", bus.rx_ready, 1);
    chk("hdr_err", herr, m_err);
    chk("pulses_d", pd - spd, (hdr == 8'h01) ? WE : 0);
    chk("pulses_i", pi - spi, (hdr == 8'h02) ? WE : 0);
  endtask

  task automatic run_go(input logic [255:0] dg);
    int idx, n;
    bit r;
    send_byte(8'h03, 0);
    chk("start_on", start, 1);
    chk("rx_ready_run", bus.rx_ready, 0);
    repeat (3) @(negedge clk);
    chk("no_early_dump", bus.tx_valid, 0);
    done = 1'b0;
    @(negedge clk);
    res  = dg;
    done = 1'b1;
    @(negedge clk);
    chk("tx_valid_first", bus.tx_valid, 1);
    res = ~dg;
    idx = 0;
    n = 0;
    while (idx < 32 && n < 1000) begin
      chk("tx_valid", bus.tx_valid, 1);
      chk("tx_byte", bus.tx_data, dg[255-8*idx -: 8]);
      r = (n > 500) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.tx_ready = r;
      @(negedge clk);
      n++;
      if (r) idx++;
    end
    bus.tx_ready = 1'b0;
    chk("dump_bytes", idx, 32);
    chk("tx_valid_off", bus.tx_valid, 0);
    chk("start_off", start, 0);
    chk("rx_ready_back", bus.rx_ready, 1);
  endtask

  logic [255:0] dg;
  logic [7:0]   b;
  int           spd, spi;

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b0;
    done = 1'b0;
    res  = '0;
    model_clear();

    repeat (3) @(negedge clk);
    chk_zero("por");
    reset = 1'b1;
    chk("rdy_at_release", bus.rx_ready, 0);
    @(negedge clk);
    chk("rdy_after_release", bus.rx_ready, 1);
    chk("count_after_release", lcnt, 0);

    send_record(8'h01, 32'h4, 32'hDEADBEEF, 0);
    send_record(8'h02, 32'h8, 32'h13, 1);

    spd = pd;
    spi = pi;
    send_byte(8'h7F, 0);
    m_err = 1'b1;
    chk("bad_hdr_err", herr, 1);
    chk("bad_hdr_rdy", bus.rx_ready, 1);
    @(negedge clk);
    chk("bad_hdr_nowrite", {pd - spd, pi - spi}, 0);
    send_record(8'h01, 32'h100, 32'h01234567, 0);

    run_go(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
    for (int i = 0; i < 8; i++) dg[32*i +: 32] = $urandom;
    run_go(dg);

    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        b = 8'($urandom);
        if (b >= 8'h01 && b <= 8'h03) b = b + 8'h10;
        send_byte(b, 0);
        m_err = 1'b1;
        chk("rand_bad_err", herr, 1);
      end
      send_record(8'($urandom_range(1, 2)), $urandom, $urandom,
                  $urandom_range(0, 2));
    end

    spd = pd;
    spi = pi;
    send_byte(8'h01, 0);
    for (int i = 0; i < 4; i++) send_byte(8'h10, 0);
    reset = 1'b0;
    #1;
    model_clear();
    chk_zero("mid_rst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_rdy", bus.rx_ready, 1);
    chk("mid_rst_nowrite", {pd - spd, pi - spi}, 0);
    send_record(8'h01, 32'h20, 32'hCAFEF00D, 0);
    chk("mid_rst_count", lcnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
